// File: rtl/fibonacci_index_finder.sv
// Inverse Fibonacci decoder: regenerates F(0), F(1), ... one term per cycle
// until the term reaches or passes the captured target, then reports its index.
module fibonacci_index_finder #(
    parameter int W  = 12,
    parameter int NW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  F,
    output logic [NW-1:0] n,
    output logic          is_fib,
    output logic          busy,
    output logic          done
);

    typedef enum logic {IDLE, SEARCH} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    target_q, target_d;
    // Two guard bits keep the first term past target from wrapping.
    logic [W+1:0]    a_q, a_d, b_q, b_d;
    logic [NW-1:0]   idx_q, idx_d;
    logic [NW-1:0]   n_q, n_d;
    logic            is_fib_q, is_fib_d;
    logic            done_q, done_d;
    logic [W+1:0]    target_ext;

    assign target_ext = {2'b00, target_q};

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        n_d      = n_q;
        is_fib_d = is_fib_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    target_d = F;
                    a_d      = '0;
                    b_d      = (W+2)'(1);
                    idx_d    = '0;
                    state_d  = SEARCH;
                end
            end
            SEARCH: begin
                if (a_q == target_ext) begin
                    n_d      = idx_q;
                    is_fib_d = 1'b1;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else if (a_q > target_ext) begin
                    // a overshot, so idx is at least 1 here and idx-1 names the term below target.
                    n_d      = idx_q - NW'(1);
                    is_fib_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    a_d   = b_q;
                    b_d   = a_q + b_q;
                    idx_d = idx_q + NW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            target_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            n_q      <= '0;
            is_fib_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            n_q      <= n_d;
            is_fib_q <= is_fib_d;
            done_q   <= done_d;
        end
    end

    assign n      = n_q;
    assign is_fib = is_fib_q;
    assign busy   = (state_q == SEARCH);
    assign done   = done_q;

endmodule

// File: tb/tb_fibonacci_index_finder.sv
// Self-checking bench for fibonacci_index_finder against an array-based
// Fibonacci reference (smallest k with F(k) >= value decides n and latency).
module tb_fibonacci_index_finder;

    localparam int W  = 12;
    localparam int NW = 5;
    localparam int BUDGET = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  F;
    logic [NW-1:0] n;
    logic          is_fib;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    fibonacci_index_finder #(.W(W), .NW(NW)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .F      (F),
        .n      (n),
        .is_fib (is_fib),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    function automatic int fib(input int k);
        int x = 0;
        int y = 1;
        for (int i = 0; i < k; i++) begin
            int t = x + y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Reference: smallest k with F(k) >= v; exact -> n=k, else n=k-1; done after k+2 edges.
    function automatic void model(input int v, output int exp_n, output bit exp_fib,
                                  output int exp_edges);
        int k = 0;
        while (fib(k) < v) k++;
        exp_fib   = (fib(k) == v);
        exp_n     = exp_fib ? k : k - 1;
        exp_edges = k + 2;
    endfunction

    // Drives one start pulse and waits (bounded) for done; returns edge count.
    task automatic do_search(input int val, output int edges, output bit seen_done);
        @(negedge clk);
        start = 1'b1;
        F     = W'(val);
        @(posedge clk);
        #1;
        start     = 1'b0;
        edges     = 1;
        seen_done = 1'b0;
        while (!seen_done && edges < BUDGET) begin
            @(posedge clk);
            #1;
            edges++;
            if (done) seen_done = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        F     = W'(55);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (n !== '0 || is_fib !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: n=%0d is_fib=%b busy=%b done=%b, need 0 0 0 0",
                     n, is_fib, busy, done);
        end
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            total++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle: busy=%b done=%b, need 0 0", busy, done);
            end
        end
    endtask

    task automatic run_directed(input string name, input int val);
        int  edges, en, ee;
        bit  seen, ef;
        model(val, en, ef, ee);
        do_search(val, edges, seen);
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s_timeout: no done within %0d edges, need done at %0d", name, BUDGET, ee);
        end else if (n !== NW'(en) || is_fib !== ef || edges !== ee || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s: n=%0d is_fib=%b edges=%0d busy=%b, need n=%0d is_fib=%b edges=%0d busy=0",
                     name, n, is_fib, edges, busy, en, ef, ee);
        end
    endtask

    task automatic test_exact();
        run_directed("exact_55", 55);
        run_directed("exact_0", 0);
        run_directed("exact_1", 1);
        run_directed("exact_2584", 2584);
    endtask

    task automatic test_non_fib();
        run_directed("nonfib_4", 4);
        run_directed("nonfib_4095", 4095);
        run_directed("nonfib_100", 100);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            int v = int'($urandom_range(0, 4095));
            run_directed("random", v);
        end
    endtask

    task automatic test_protocol();
        int  edges;
        bit  seen;
        @(negedge clk);
        start = 1'b1;
        F     = W'(610);
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 1;
        seen  = 1'b0;
        while (!seen && edges < BUDGET) begin
            if (edges == 4) begin
                start = 1'b1;
                F     = W'(3);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            edges++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        total++;
        if (!seen || n !== NW'(15) || is_fib !== 1'b1 || edges !== 17) begin
            bad++;
            $display("FAIL busy_start_ignored: seen=%b n=%0d is_fib=%b edges=%0d, need 1 15 1 17",
                     seen, n, is_fib, edges);
        end
        // Still in the done cycle: request a new search to be sampled on the next edge.
        start = 1'b1;
        F     = W'(3);
        @(posedge clk);
        #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL done_cycle_start: busy=%b done=%b, need 1 0", busy, done);
        end
        edges = 1;
        seen  = 1'b0;
        while (!seen && edges < BUDGET) begin
            @(posedge clk);
            #1;
            edges++;
            if (done) seen = 1'b1;
        end
        total++;
        if (!seen || n !== NW'(4) || is_fib !== 1'b1 || edges !== 6) begin
            bad++;
            $display("FAIL done_cycle_result: seen=%b n=%0d is_fib=%b edges=%0d, need 1 4 1 6",
                     seen, n, is_fib, edges);
        end
    endtask

    task automatic test_reset_mid();
        bit stray = 1'b0;
        @(negedge clk);
        start = 1'b1;
        F     = W'(987);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || n !== '0 || is_fib !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: busy=%b done=%b n=%0d is_fib=%b, need 0 0 0 0",
                     busy, done, n, is_fib);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done || busy) stray = 1'b1;
        end
        total++;
        if (stray) begin
            bad++;
            $display("FAIL reset_mid_quiet: activity=1, need 0");
        end
        run_directed("after_reset_21", 21);
    endtask

    task automatic test_closed_loop();
        for (int k = 0; k <= 15; k++) begin
            int  edges;
            bit  seen;
            int  en = (k == 2) ? 1 : k;
            do_search(fib(k), edges, seen);
            total++;
            if (!seen || n !== NW'(en) || is_fib !== 1'b1) begin
                bad++;
                $display("FAIL closed_loop_%0d: seen=%b n=%0d is_fib=%b, need 1 %0d 1",
                         k, seen, n, is_fib, en);
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        F     = '0;
        test_reset();
        test_exact();
        test_non_fib();
        test_protocol();
        test_reset_mid();
        test_closed_loop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fibonacci_index_finder.md
Name: fibonacci_index_finder

Overview:
- Inverse of the Fibonacci generator: takes a W-bit value and finds its Fibonacci index n, where F(0)=0, F(1)=1 and F(k)=F(k-1)+F(k-2).
- Regenerates the sequence iteratively, one term per cycle, until the term reaches or passes the target.
- Reports the index and whether the value is an exact Fibonacci number.
- Sits beside the generator as its checker/decoder, so a bench or system can close the loop n -> F -> n.

Parameters:
- W, 12, width of the input value.
- NW, 5, width of the index output; must hold the largest index k with F(k) < 2^W (18 for W=12).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- F  input  W  value to decode; captured on the accepted start edge.
- n  output  NW  result index.
- is_fib  output  1  1 = F is an exact Fibonacci number.
- busy  output  1  high while in SEARCH.
- done  output  1  one-cycle pulse when n and is_fib become valid.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: takes effect on the rising clk edge with rst=1, including mid-search. It forces state=IDLE, n=0, is_fib=0, busy=0, done=0, and clears the internal registers.
- Internal registers:
  - target (W bits).
  - a, b: W+2 bits each, so a term past target cannot wrap.
  - idx: NW bits.
- FSM states: IDLE, SEARCH.
- IDLE:
  - done is 0 except in the first cycle after a search completes.
  - On an edge with start=1: target<=F, a<=0, b<=1, idx<=0, state<=SEARCH, busy<=1.
- SEARCH, each edge compares a (which equals F(idx)) with target:
  - a==target: n<=idx, is_fib<=1, done<=1, busy<=0, state<=IDLE.
  - a>target: n<=idx-1 (index of the largest Fibonacci number below target), is_fib<=0, done<=1, busy<=0, state<=IDLE.
  - a<target: a<=b, b<=a+b, idx<=idx+1; stay in SEARCH.
- done lasts exactly one cycle and is cleared on the next edge.
- n and is_fib hold their values until the next completion or reset.
- Value 1 (indices 1 and 2 both qualify): report the smallest, n=1.
- Value 0: n=0, is_fib=1.
- Latency: target equal to F(k) gives done high after k+2 rising edges, counting the start edge as edge 1. A non-Fibonacci target with F(k-1) < target < F(k) also gives k+2 edges, with n=k-1.
- Worst case for W=12: target 4095 exits at a=F(19)=4181, giving 21 edges and n=18.
- start while busy: ignored; the running search and the captured target are unaffected.
- start in the done cycle: accepted, because state is already IDLE. done and busy are then not both high; done=1 in that cycle and busy rises on the next edge.
- F changing after capture: no effect on the running search.
- rst and start on the same edge: rst wins and state stays IDLE.

Test Plan:
- Reset: assert rst for 2 edges with start=1 -> n=0, is_fib=0, busy=0, done=0 and state IDLE. After release with start low, nothing happens.
- Exact hit: F=55, one-cycle start -> busy high for 11 cycles, then done pulse 12 edges after start with n=10, is_fib=1. Repeat for F=0 (n=0, 2 edges), F=1 (n=1), and F=2584 (n=18, 20 edges).
- Non-Fibonacci: F=4 -> n=4, is_fib=0, 7 edges. F=4095 -> n=18, is_fib=0, 21 edges. F=100 -> n=11, is_fib=0.
- Protocol: F=610 running (n=15 expected), pulse start with F=3 at cycle 5 -> ignored; result n=15, is_fib=1. Start with F=3 in the done cycle -> accepted; next result n=4, is_fib=1.
- Reset mid-operation: F=987, assert rst at cycle 8 -> next edge busy=0, no done pulse, n=0. A fresh start with F=21 then gives n=8, is_fib=1.
- Closed loop: for n_in = 0..15, drive the Fibonacci generator and feed its F into this block -> returned n equals n_in and is_fib=1 for all, except n_in=2, which returns n=1.
